prbs_checker: RTL

Receive-side companion to the 8-bit LFSR random generator. It takes the 8-bit word stream from an LFSR source, self-synchronises to the sequence, and then flywheels an internal prediction. It flags every word that departs from the prediction and keeps a saturating error count. It sits at the sink end of any LFSR-driven datapath as a built-in self-test monitor.

---
 rtl/prbs_checker_pkg.sv | 18 +
 rtl/prbs_checker.sv | 106 ++++++++++
 2 files changed

// File: rtl/prbs_checker_pkg.sv
// Shared LFSR definitions for the 8-bit PRBS generator/checker pair.
// Both ends call lfsr_next so the polynomial exists in exactly one place.
package prbs_checker_pkg;

  localparam int                LFSR_W    = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  // Shift left, feeding back the XOR of taps 7,5,4,3.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: searches for LOCK_COUNT consecutive successor
// words, then flywheels a prediction and counts mismatches while locked.
module prbs_checker
  import prbs_checker_pkg::*;
#(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3,
  parameter int ERR_CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [LFSR_W-1:0]    in_data,
  input  logic                 err_clr,
  output logic                 locked,
  output logic                 error,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [3:0] LOCK_CNT_C   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_CNT_C = 4'(UNLOCK_COUNT);

  chk_state_t           state, state_nxt;
  logic [3:0]           match_cnt, match_nxt;
  logic [3:0]           miss_cnt, miss_nxt;
  logic                 have_prev, have_prev_nxt;
  logic [LFSR_W-1:0]    prev, prev_nxt;
  logic [LFSR_W-1:0]    expected, expected_nxt;
  logic                 error_nxt;
  logic [ERR_CNT_W-1:0] err_count_nxt;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_comb begin
    state_nxt     = state;
    match_nxt     = match_cnt;
    miss_nxt      = miss_cnt;
    have_prev_nxt = have_prev;
    prev_nxt      = prev;
    expected_nxt  = expected;
    error_nxt     = 1'b0;
    err_count_nxt = err_count;

    if (in_valid) begin
      if (state == SEARCH) begin
        prev_nxt      = in_data;
        have_prev_nxt = 1'b1;
        if (have_prev && (in_data == lfsr_next(prev)) && (in_data != '0)) begin
          match_nxt = match_cnt + 4'd1;
          if (match_nxt == LOCK_CNT_C) begin
            state_nxt    = LOCKED;
            expected_nxt = lfsr_next(in_data);
            miss_nxt     = '0;
          end
        end else begin
          match_nxt = '0;
        end
      end else begin
        // Prediction never reseeds from received data: one bad word, one error.
        expected_nxt = lfsr_next(expected);
        if (in_data == expected) begin
          miss_nxt = '0;
        end else begin
          error_nxt     = 1'b1;
          err_count_nxt = sat_inc(err_count);
          miss_nxt      = miss_cnt + 4'd1;
          if (miss_nxt == UNLOCK_CNT_C) begin
            state_nxt     = SEARCH;
            match_nxt     = '0;
            prev_nxt      = in_data;
            have_prev_nxt = 1'b1;
          end
        end
      end
    end

    if (err_clr) err_count_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEARCH;
      match_cnt <= '0;
      miss_cnt  <= '0;
      have_prev <= 1'b0;
      prev      <= '0;
      expected  <= '0;
      error     <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
      have_prev <= have_prev_nxt;
      prev      <= prev_nxt;
      expected  <= expected_nxt;
      error     <= error_nxt;
      err_count <= err_count_nxt;
    end
  end

  assign locked = (state == LOCKED);

endmodule
